// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing output bundle from video_timing_gen to the pixel pipeline
interface video_timing_gen_if #(
  parameter int CNT_W   = 12,
  parameter int FRAME_W = 8
);
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [CNT_W-1:0]   px;
  logic [CNT_W-1:0]   py;
  logic               sol;
  logic               sof;
  logic               eof;
  logic [FRAME_W-1:0] frame_cnt;
  logic               fetch_de;
  logic [CNT_W-1:0]   fetch_x;
  logic [CNT_W-1:0]   fetch_y;

  modport master (
    output hsync, vsync, de, px, py, sol, sof, eof, frame_cnt,
    output fetch_de, fetch_x, fetch_y
  );

  modport slave (
    input hsync, vsync, de, px, py, sol, sof, eof, frame_cnt,
    input fetch_de, fetch_x, fetch_y
  );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator; VTG_LOOKAHEAD_EN adds the fetch-lookahead channel
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 12,
  parameter int FRAME_W   = 8,
  parameter int LOOKAHEAD = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_ce,
  video_timing_gen_if.master  vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int W       = CNT_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  if (H_TOTAL > (1 << CNT_W)) begin : g_h_range
    $error("video_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_v_range
    $error("video_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end
  if (LOOKAHEAD < 1 || LOOKAHEAD > H_FP + H_SYNC + H_BP) begin : g_la_range
    $error("video_timing_gen: LOOKAHEAD outside 1..horizontal blanking");
  end

  // Decode thresholds are one bit wider so a sync region ending exactly at
  // 2^CNT_W still compares correctly.
  localparam logic [W-1:0] H_ACT_C = W'(H_ACTIVE);
  localparam logic [W-1:0] HS_ON   = W'(H_ACTIVE + H_FP);
  localparam logic [W-1:0] HS_OFF  = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W-1:0] V_ACT_C = W'(V_ACTIVE);
  localparam logic [W-1:0] VS_ON   = W'(V_ACTIVE + V_FP);
  localparam logic [W-1:0] VS_OFF  = W'(V_ACTIVE + V_FP + V_SYNC);

  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_EOF   = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t V_EOF   = cnt_t'(V_ACTIVE - 1);

  function automatic logic active_at(cnt_t hc, cnt_t vc);
    return ({1'b0, hc} < H_ACT_C) && ({1'b0, vc} < V_ACT_C);
  endfunction

  function automatic cnt_t h_next(cnt_t hc);
    return (hc == H_LAST) ? '0 : hc + 1'b1;
  endfunction

  function automatic cnt_t v_next(cnt_t hc, cnt_t vc);
    if (hc != H_LAST) begin
      return vc;
    end
    return (vc == V_LAST) ? '0 : vc + 1'b1;
  endfunction

  cnt_t               h;
  cnt_t               v;
  logic               hsync_q;
  logic               vsync_q;
  logic               de_q;
  cnt_t               px_q;
  cnt_t               py_q;
  logic               sol_q;
  logic               sof_q;
  logic               eof_q;
  logic [FRAME_W-1:0] frame_q;
  logic               first_frame;

  logic hs_act;
  logic vs_act;

  always_comb begin
    hs_act = ({1'b0, h} >= HS_ON) && ({1'b0, h} < HS_OFF);
    vs_act = ({1'b0, v} >= VS_ON) && ({1'b0, v} < VS_OFF);
  end

  // Outputs register the decode of the pre-increment position, so every
  // output of one cycle describes the same pixel (px,py).
  always_ff @(posedge clk) begin
    if (reset) begin
      h           <= '0;
      v           <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      sol_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      frame_q     <= '0;
      first_frame <= 1'b1;
    end else if (pix_ce) begin
      hsync_q <= hs_act ? HS_POL : ~HS_POL;
      vsync_q <= vs_act ? VS_POL : ~VS_POL;
      de_q    <= active_at(h, v);
      px_q    <= h;
      py_q    <= v;
      sol_q   <= (h == '0);
      sof_q   <= (h == '0) && (v == '0);
      eof_q   <= (h == H_EOF) && (v == V_EOF);
      // The first frame after reset is frame 0; later frame starts count up.
      if ((h == '0) && (v == '0)) begin
        if (!first_frame) begin
          frame_q <= frame_q + 1'b1;
        end
        first_frame <= 1'b0;
      end
      h <= h_next(h);
      v <= v_next(h, v);
    end else begin
      sol_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
    end
  end

  assign vid.hsync     = hsync_q;
  assign vid.vsync     = vsync_q;
  assign vid.de        = de_q;
  assign vid.px        = px_q;
  assign vid.py        = py_q;
  assign vid.sol       = sol_q;
  assign vid.sof       = sof_q;
  assign vid.eof       = eof_q;
  assign vid.frame_cnt = frame_q;

`ifdef VTG_LOOKAHEAD_EN
  cnt_t fh;
  cnt_t fv;
  logic fetch_de_q;
  cnt_t fetch_x_q;
  cnt_t fetch_y_q;

  // Runs in lockstep with (h,v), offset by LOOKAHEAD ticks from reset on.
  always_ff @(posedge clk) begin
    if (reset) begin
      fh         <= cnt_t'(LOOKAHEAD);
      fv         <= '0;
      fetch_de_q <= 1'b0;
      fetch_x_q  <= '0;
      fetch_y_q  <= '0;
    end else if (pix_ce) begin
      fetch_de_q <= active_at(fh, fv);
      fetch_x_q  <= fh;
      fetch_y_q  <= fv;
      fh         <= h_next(fh);
      fv         <= v_next(fh, fv);
    end
  end

  assign vid.fetch_de = fetch_de_q;
  assign vid.fetch_x  = fetch_x_q;
  assign vid.fetch_y  = fetch_y_q;
`else
  assign vid.fetch_de = 1'b0;
  assign vid.fetch_x  = '0;
  assign vid.fetch_y  = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen (small raster, both polarities)
module tb_video_timing_gen;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CNT_W(12), .FRAME_W(8)) vid0 ();
  video_timing_gen_if #(.CNT_W(12), .FRAME_W(2)) vid1 ();

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12), .FRAME_W(8), .LOOKAHEAD(2)
  ) dut0 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vid(vid0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12), .FRAME_W(2), .LOOKAHEAD(2)
  ) dut1 (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .vid(vid1)
  );

  // Model: n = enabled ticks since reset; output pixel is raster index n-1.
  int n = 0;
  bit last_tick = 1'b0;
  bit started = 1'b0;
  int phase = 0;

  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      last_tick = 1'b0;
      started = 1'b1;
    end else if (pix_ce) begin
      n = n + 1;
      last_tick = 1'b1;
    end else begin
      last_tick = 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int prev_sof = -1;
  int run = 0;
  int last_run = 0;
  int prev_phase = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic check_dut(input string t, input logic hpol, input logic vpol, input int fw,
                           input logic hs, input logic vs, input logic de_a,
                           input logic [11:0] px_a, input logic [11:0] py_a,
                           input logic sol_a, input logic sof_a, input logic eof_a,
                           input logic [7:0] fc_a, input logic fde_a,
                           input logic [11:0] fx_a, input logic [11:0] fy_a);
    int p, ex, ey, efc, efx, efy, q;
    logic e_de, e_hs, e_vs, e_sol, e_sof, e_eof, e_fde;
    ex = 0; ey = 0; efc = 0; efx = 0; efy = 0;
    e_de = 1'b0; e_hs = ~hpol; e_vs = ~vpol;
    e_sol = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_fde = 1'b0;
    if (n > 0) begin
      p   = n - 1;
      ex  = p % HT;
      ey  = (p / HT) % VT;
      efc = (p / FT) % (1 << fw);
      e_de = (ex < 8) && (ey < 4);
      e_hs = (ex >= 10 && ex < 13) ? hpol : ~hpol;
      e_vs = (ey >= 5 && ey < 7) ? vpol : ~vpol;
      e_sol = last_tick && (ex == 0);
      e_sof = last_tick && (ex == 0) && (ey == 0);
      e_eof = last_tick && (ex == 7) && (ey == 3);
`ifdef VTG_LOOKAHEAD_EN
      q   = p + 2;
      efx = q % HT;
      efy = (q / HT) % VT;
      e_fde = (efx < 8) && (efy < 4);
`else
      q = 0;
`endif
    end
    chk({t, ".hsync"},    32'(hs),    32'(e_hs));
    chk({t, ".vsync"},    32'(vs),    32'(e_vs));
    chk({t, ".de"},       32'(de_a),  32'(e_de));
    chk({t, ".px"},       32'(px_a),  ex);
    chk({t, ".py"},       32'(py_a),  ey);
    chk({t, ".sol"},      32'(sol_a), 32'(e_sol));
    chk({t, ".sof"},      32'(sof_a), 32'(e_sof));
    chk({t, ".eof"},      32'(eof_a), 32'(e_eof));
    chk({t, ".frame"},    32'(fc_a),  efc);
    chk({t, ".fetch_de"}, 32'(fde_a), 32'(e_fde));
    chk({t, ".fetch_x"},  32'(fx_a),  efx);
    chk({t, ".fetch_y"},  32'(fy_a),  efy);
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (started) begin
      check_dut("dut0", 1'b0, 1'b0, 8, vid0.hsync, vid0.vsync, vid0.de, vid0.px, vid0.py,
                vid0.sol, vid0.sof, vid0.eof, vid0.frame_cnt,
                vid0.fetch_de, vid0.fetch_x, vid0.fetch_y);
      check_dut("dut1", 1'b1, 1'b1, 2, vid1.hsync, vid1.vsync, vid1.de, vid1.px, vid1.py,
                vid1.sol, vid1.sof, vid1.eof, 8'(vid1.frame_cnt),
                vid1.fetch_de, vid1.fetch_x, vid1.fetch_y);

      // Hand-computed literal points.
      if (last_tick && n == 1) begin
        chk("first.px", 32'(vid0.px), 0);
        chk("first.py", 32'(vid0.py), 0);
        chk("first.sof", 32'(vid0.sof), 1);
        chk("first.sol", 32'(vid0.sol), 1);
        chk("first.de", 32'(vid0.de), 1);
        chk("first.frame", 32'(vid0.frame_cnt), 0);
      end
      if (last_tick && n > 0 && (n - 1) % FT == 10) begin
        chk("h10.hsync_low", 32'(vid0.hsync), 0);
        chk("h10.hsync_high_pol1", 32'(vid1.hsync), 1);
      end
      if (last_tick && n > 0 && (n - 1) % FT == 52) chk("eof_at_7_3", 32'(vid0.eof), 1);
      if (phase == 1 && n == 361) chk("frame3", 32'(vid0.frame_cnt), 3);
      if (phase == 1 && n == 480) chk("fw2.frame3", 32'(vid1.frame_cnt), 3);
      if (phase == 1 && n == 481) chk("fw2.wrap", 32'(vid1.frame_cnt), 0);
      if (phase == 3 && n == 36) begin
        chk("mid.px", 32'(vid0.px), 5);
        chk("mid.py", 32'(vid0.py), 2);
      end
      if (phase == 3 && n == 0) begin
        chk("rst.hsync0", 32'(vid0.hsync), 1);
        chk("rst.vsync0", 32'(vid0.vsync), 1);
        chk("rst.hsync1", 32'(vid1.hsync), 0);
        chk("rst.vsync1", 32'(vid1.vsync), 0);
        chk("rst.de", 32'(vid0.de), 0);
        chk("rst.frame", 32'(vid0.frame_cnt), 0);
      end
`ifdef VTG_LOOKAHEAD_EN
      if (n > 0 && (n - 1) % FT == 118) begin
        chk("la_wrap.fetch_de", 32'(vid0.fetch_de), 1);
        chk("la_wrap.fetch_x", 32'(vid0.fetch_x), 0);
        chk("la_wrap.fetch_y", 32'(vid0.fetch_y), 0);
      end
`endif

      if (reset) begin
        prev_sof = -1;
      end else if (vid0.sof) begin
        if (phase == 1 && prev_sof >= 0) chk("sof_period", cyc - prev_sof, FT);
        prev_sof = cyc;
      end

      if (vid0.hsync == 1'b0) begin
        run = run + 1;
      end else begin
        if (run > 0) last_run = run;
        run = 0;
      end

      if (phase != prev_phase) begin
        if (prev_phase == 1) chk("hsync_clks_ce1", last_run, 3);
        if (prev_phase == 2) chk("hsync_clks_ce_toggle", last_run, 6);
        prev_phase = phase;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    pix_ce = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    phase = 1;
    repeat (620) @(posedge clk);
    #2 phase = 2;
    for (int i = 0; i < 130; i++) begin
      pix_ce = ~pix_ce;
      @(posedge clk);
      #2;
    end
    phase  = 3;
    pix_ce = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (36) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
